// File: rtl/sia_pkg.sv
// rtl/sia_pkg.sv - shared register map, bit positions and TX state encoding for the SIA UART transmitter
package sia_pkg;

    localparam logic [2:0] REG_DATA   = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_DIV_LO = 3'd2;
    localparam logic [2:0] REG_DIV_HI = 3'd3;
    localparam logic [2:0] REG_CTRL   = 3'd4;

    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;

    localparam int CTRL_TX_EN  = 0;
    localparam int CTRL_IRQ_EN = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/sia_uart_tx_if.sv
// rtl/sia_uart_tx_if.sv - 65816 bus signals seen by the SIA UART transmit window
interface sia_uart_tx_if;

    logic       phi2;
    logic       read_write;
    logic       sia_n;
    logic [2:0] address;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       data_oe;

    modport master (
        output phi2, read_write, sia_n, address, data_in,
        input  data_out, data_oe
    );

    modport slave (
        input  phi2, read_write, sia_n, address, data_in,
        output data_out, data_oe
    );

endinterface

// File: rtl/sia_tx_fifo.sv
// rtl/sia_tx_fifo.sv - synchronous TX byte FIFO with wrap-bit pointers and show-ahead read data
module sia_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // a push into a full FIFO is accepted when the head leaves in the same clock
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/sia_uart_tx.sv
// rtl/sia_uart_tx.sv - SIA UART transmit register window: bus sync, registers, FIFO and 8N1 serialiser
module sia_uart_tx
    import sia_pkg::*;
#(
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [15:0] DEFAULT_DIV = 16'd123,
    parameter int          SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    sia_uart_tx_if.slave  bus,
    output logic          irq_n,
    output logic          tx
);

    localparam int SYNC_W = 14;
    localparam logic [SYNC_W-1:0] SYNC_IDLE = {1'b0, 1'b1, 1'b1, 3'd0, 8'd0};

    // address/data ride the same pipeline as phi2 so they stay aligned with the sampled edge
    logic [SYNC_W-1:0] sync_q [SYNC_STAGES];
    logic              phi2_s, rw_s, sia_n_s, phi2_d;
    logic [2:0]        addr_s;
    logic [7:0]        wdata_s;

    logic [15:0]       div;
    logic [1:0]        ctrl;
    logic              ovf;
    logic              wr_commit, push_req, ovf_set;
    logic [7:0]        rd_mux;

    logic              fifo_pop, fifo_full, fifo_empty;
    logic [7:0]        fifo_rdata;

    tx_state_t         state, state_next;
    logic [15:0]       bit_div, baud_cnt;
    logic [2:0]        bit_cnt;
    logic [7:0]        shreg;
    logic              bit_end, load_frame, shift, tx_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_IDLE;
            phi2_d <= 1'b0;
        end else begin
            sync_q[0] <= {bus.phi2, bus.read_write, bus.sia_n, bus.address, bus.data_in};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            phi2_d <= phi2_s;
        end
    end

    assign {phi2_s, rw_s, sia_n_s, addr_s, wdata_s} = sync_q[SYNC_STAGES-1];
    assign wr_commit = phi2_d && !phi2_s && !sia_n_s && !rw_s;
    assign push_req  = wr_commit && (addr_s == REG_DATA);
    assign ovf_set   = push_req && fifo_full && !fifo_pop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div  <= DEFAULT_DIV;
            ctrl <= 2'b00;
            ovf  <= 1'b0;
        end else begin
            if (ovf_set) ovf <= 1'b1;
            if (wr_commit) begin
                case (addr_s)
                    REG_STATUS: if (wdata_s[ST_OVF]) ovf <= 1'b0;
                    REG_DIV_LO: div[7:0]  <= wdata_s;
                    REG_DIV_HI: div[15:8] <= wdata_s;
                    REG_CTRL:   ctrl      <= wdata_s[1:0];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_mux = 8'h00;
        case (addr_s)
            REG_STATUS: begin
                rd_mux[ST_FULL]  = fifo_full;
                rd_mux[ST_EMPTY] = fifo_empty;
                rd_mux[ST_BUSY]  = (state != IDLE);
                rd_mux[ST_OVF]   = ovf;
            end
            REG_DIV_LO: rd_mux = div[7:0];
            REG_DIV_HI: rd_mux = div[15:8];
            REG_CTRL:   rd_mux = {6'b0, ctrl};
            default:    rd_mux = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.data_oe  <= 1'b0;
            bus.data_out <= 8'h00;
            irq_n        <= 1'b1;
        end else begin
            bus.data_oe  <= !sia_n_s && rw_s && phi2_s;
            bus.data_out <= rd_mux;
            irq_n        <= !(ctrl[CTRL_IRQ_EN] && fifo_empty && (state == IDLE));
        end
    end

    sia_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push_req),
        .pop     (fifo_pop),
        .wdata   (wdata_s),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // a queued byte at the end of STOP starts straight away so frames abut with no idle clock
    always_comb begin
        state_next = state;
        fifo_pop   = 1'b0;
        load_frame = 1'b0;
        shift      = 1'b0;
        bit_end    = (baud_cnt == bit_div);
        case (state)
            IDLE: begin
                if (ctrl[CTRL_TX_EN] && !fifo_empty) begin
                    fifo_pop   = 1'b1;
                    load_frame = 1'b1;
                    state_next = START;
                end
            end
            START: if (bit_end) state_next = DATA;
            DATA: begin
                if (bit_end) begin
                    shift = 1'b1;
                    if (bit_cnt == 3'd7) state_next = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (ctrl[CTRL_TX_EN] && !fifo_empty) begin
                        fifo_pop   = 1'b1;
                        load_frame = 1'b1;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift ? shreg[1] : shreg[0];
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_div  <= 16'd0;
            baud_cnt <= 16'd0;
            bit_cnt  <= 3'd0;
            shreg    <= 8'h00;
            tx       <= 1'b1;
        end else begin
            tx <= tx_next;
            if (load_frame) begin
                bit_div  <= div;
                shreg    <= fifo_rdata;
                baud_cnt <= 16'd0;
                bit_cnt  <= 3'd0;
            end else if (state != IDLE) begin
                baud_cnt <= bit_end ? 16'd0 : baud_cnt + 16'd1;
                if (shift) begin
                    shreg   <= {1'b0, shreg[7:1]};
                    bit_cnt <= bit_cnt + 3'd1;
                end
            end
        end
    end

endmodule
